// File: rtl/csa_accum_ctrl_if.sv
// Handshake bundle for the carry-save accumulator controller.
//   cmd channel : cmd_valid/cmd_ready with cmd_count (operands in the command)
//   op channel  : op_valid/op_ready with op_data (unsigned operand)
//   res channel : res_valid/res_ready with res_data (binary sum, OP_W+CNT_W bits)
//   busy        : controller status, high whenever a command is in flight
// master = command/operand producer and result consumer; slave = controller.
interface csa_accum_ctrl_if #(
  parameter int OP_W  = 17,
  parameter int CNT_W = 4
);
  localparam int ACC_W = OP_W + CNT_W;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_count;
  logic             op_valid;
  logic             op_ready;
  logic [OP_W-1:0]  op_data;
  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] res_data;
  logic             busy;

  modport master (
    output cmd_valid, cmd_count, op_valid, op_data, res_ready,
    input  cmd_ready, op_ready, res_valid, res_data, busy
  );

  modport slave (
    input  cmd_valid, cmd_count, op_valid, op_data, res_ready,
    output cmd_ready, op_ready, res_valid, res_data, busy
  );
endinterface

// File: rtl/csa_accum_ctrl.sv
// Sequencer for a multi-operand accumulator built on one 3:2 compressor.
// A command supplies an operand count; that many operands are folded into a
// redundant sum/carry pair, then one registered carry-propagate add produces
// the binary result, offered on a valid/ready channel.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : csa_accum_ctrl_if.slave (cmd / op / res channels and busy)
module csa_accum_ctrl #(
  parameter int OP_W  = 17,
  parameter int CNT_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  csa_accum_ctrl_if.slave bus
);
  // Wide enough for (2^CNT_W-1) operands of 2^OP_W-1: the sum never overflows.
  localparam int ACC_W = OP_W + CNT_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t           state, state_next;
  logic [ACC_W-1:0] sum_reg, carry_reg, res_reg;
  logic [CNT_W-1:0] remaining;
  // RESOLVE spans two edges: the first registers the carry-propagate add,
  // the second presents it, so res_valid follows the last accept by two edges.
  logic             resolve_phase;

  logic             cmd_ready, op_ready, res_valid, busy;
  logic             cmd_fire, op_fire, res_fire;
  logic [ACC_W-1:0] op_ext, csa_sum, csa_maj;

  assign cmd_fire = bus.cmd_valid & cmd_ready;
  assign op_fire  = bus.op_valid & op_ready;
  assign res_fire = res_valid & bus.res_ready;

  // 3:2 compressor on the redundant pair and the zero-extended operand.
  assign op_ext  = ACC_W'(bus.op_data);
  assign csa_sum = sum_reg ^ carry_reg ^ op_ext;
  assign csa_maj = (sum_reg & carry_reg) | (sum_reg & op_ext) | (carry_reg & op_ext);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  // NOTE: the default assignment at the top of each always_comb keeps every
  // path assigned, so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (cmd_fire) state_next = (bus.cmd_count != '0) ? ACCUM : RESOLVE;
      ACCUM:   if (op_fire && remaining == CNT_W'(1)) state_next = RESOLVE;
      RESOLVE: if (resolve_phase) state_next = DONE;
      DONE:    if (res_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: all handshake outputs decode directly from the state, so
  // they are glitch-free relative to inputs and reset with the state.
  always_comb begin
    cmd_ready = 1'b0;
    op_ready  = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE:    begin cmd_ready = 1'b1; busy = 1'b0; end
      ACCUM:   op_ready  = 1'b1;
      RESOLVE: ;
      DONE:    res_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath registers.
  // NOTE: every datapath register is reset so an interrupted command leaves
  // no partial sum or stale result behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_reg       <= '0;
      carry_reg     <= '0;
      remaining     <= '0;
      res_reg       <= '0;
      resolve_phase <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_fire) begin
            sum_reg   <= '0;
            carry_reg <= '0;
            remaining <= bus.cmd_count;
          end
        end
        ACCUM: begin
          if (op_fire) begin
            sum_reg   <= csa_sum;
            // Majority bits carry into the next weight; the MSB falls off,
            // which is safe because the true total fits in ACC_W.
            carry_reg <= {csa_maj[ACC_W-2:0], 1'b0};
            remaining <= remaining - CNT_W'(1);
          end
        end
        RESOLVE: begin
          if (!resolve_phase) res_reg <= sum_reg + carry_reg;
          resolve_phase <= ~resolve_phase;
        end
        DONE: ;  // res_reg holds until the consumer takes it
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.op_ready  = op_ready;
  assign bus.res_valid = res_valid;
  assign bus.res_data  = res_reg;
  assign bus.busy      = busy;
endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Directed bench for csa_accum_ctrl: hand-computed sums, exact result latency,
// result hold under back-pressure, async reset mid-command, IDLE operand filter.
module tb_csa_accum_ctrl;
  localparam int OP_W    = 17;
  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 50;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  csa_accum_ctrl_if #(.OP_W(OP_W), .CNT_W(CNT_W)) bus ();

  csa_accum_ctrl #(.OP_W(OP_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  // All tasks start and end at a falling edge; the accepting rising edge lies
  // inside the task.
  task automatic send_cmd(input logic [CNT_W-1:0] cnt);
    int t = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_count = cnt;
    while (!bus.cmd_ready && t < TIMEOUT) begin @(negedge clk); t++; end
    check("cmd_accept_in_time", 32'(t < TIMEOUT), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic send_op(input logic [OP_W-1:0] data, input int gap);
    int t = 0;
    for (int g = 0; g < gap; g++) begin
      bus.op_valid = 1'b0;
      @(negedge clk);
      check("gap_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    end
    bus.op_valid = 1'b1;
    bus.op_data  = data;
    while (!bus.op_ready && t < TIMEOUT) begin @(negedge clk); t++; end
    check("op_accept_in_time", 32'(t < TIMEOUT), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.op_valid = 1'b0;
  endtask

  // Called right after the last accepting edge k: result must appear after k+2.
  task automatic expect_result(input string tag, input logic [31:0] exp);
    check({tag, "_valid_k"}, 32'(bus.res_valid), 32'd0);
    check({tag, "_opready_k"}, 32'(bus.op_ready), 32'd0);
    @(negedge clk);
    check({tag, "_valid_k1"}, 32'(bus.res_valid), 32'd0);
    check({tag, "_opready_k1"}, 32'(bus.op_ready), 32'd0);
    @(negedge clk);
    check({tag, "_valid_k2"}, 32'(bus.res_valid), 32'd1);
    check({tag, "_data"}, 32'(bus.res_data), exp);
    check({tag, "_cmd_ready_done"}, 32'(bus.cmd_ready), 32'd0);
    check({tag, "_busy_done"}, 32'(bus.busy), 32'd1);
  endtask

  // res_ready must already be high: the next edge is the result handshake.
  task automatic finish_handshake(input string tag);
    @(negedge clk);
    check({tag, "_valid_cleared"}, 32'(bus.res_valid), 32'd0);
    check({tag, "_cmd_ready_back"}, 32'(bus.cmd_ready), 32'd1);
    check({tag, "_busy_clear"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_count = '0;
    bus.op_valid  = 1'b0;
    bus.op_data   = '0;
    bus.res_ready = 1'b1;
    repeat (2) @(negedge clk);

    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_op_ready", 32'(bus.op_ready), 32'd0);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_res_data", 32'(bus.res_data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 3 operands back-to-back: 1+2+3.
    send_cmd(4'd3);
    check("t1_busy", 32'(bus.busy), 32'd1);
    check("t1_op_ready", 32'(bus.op_ready), 32'd1);
    send_op(17'd1, 0);
    send_op(17'd2, 0);
    send_op(17'd3, 0);
    expect_result("t1", 32'd6);
    finish_handshake("t1");

    // 15 full-scale operands: no truncation.
    send_cmd(4'd15);
    for (int i = 0; i < 15; i++) send_op(17'h1FFFF, 0);
    expect_result("t2", 32'h1DFFF1);
    finish_handshake("t2");

    // Zero-operand command.
    send_cmd(4'd0);
    expect_result("t3", 32'd0);
    finish_handshake("t3");

    // Gapped operands and a consumer that stalls five cycles.
    bus.res_ready = 1'b0;
    send_cmd(4'd2);
    send_op(17'h15555, int'($urandom_range(1, 3)));
    send_op(17'h0AAAA, int'($urandom_range(1, 3)));
    expect_result("t4", 32'h1FFFF);
    for (int i = 0; i < 5; i++) begin
      bus.cmd_valid = 1'b1;  // a waiting command must be held off
      @(negedge clk);
      check("t4_hold_valid", 32'(bus.res_valid), 32'd1);
      check("t4_hold_data", 32'(bus.res_data), 32'h1FFFF);
      check("t4_hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    end
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    finish_handshake("t4");

    // Reset in the middle of a 4-operand command.
    send_cmd(4'd4);
    send_op(17'h00100, 0);
    send_op(17'h00200, 0);
    rst_n = 1'b0;
    #1;
    check("t5_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("t5_rst_op_ready", 32'(bus.op_ready), 32'd0);
    check("t5_rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("t5_rst_busy", 32'(bus.busy), 32'd0);
    check("t5_rst_res_data", 32'(bus.res_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_cmd(4'd1);
    send_op(17'd7, 0);
    expect_result("t5", 32'd7);
    finish_handshake("t5");

    // Operand offered in IDLE is ignored.
    bus.op_valid = 1'b1;
    bus.op_data  = 17'h01234;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_idle_op_ready", 32'(bus.op_ready), 32'd0);
      check("t6_idle_busy", 32'(bus.busy), 32'd0);
    end
    bus.op_valid = 1'b0;
    send_cmd(4'd1);
    send_op(17'd5, 0);
    expect_result("t6", 32'd5);
    finish_handshake("t6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
